// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle between a requester and the binary-to-BCD converter.
// The requester drives start/value and the converter returns status and digit codes.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   digits;
    logic                  overflow;

    modport master (
        output start, value,
        input  busy, done, digits, overflow
    );

    modport slave (
        input  start, value,
        output busy, done, digits, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, feeding
// per-digit 7-segment decoders (4'hF = blank, 4'hA = "F" shown on overflow).
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | add-3 / shift one binary bit into the BCD accumulator per edge
// LATCH | publish digits/overflow and pulse done
module bin2bcd_seq #(
    parameter int WIDTH    = 10,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    bin2bcd_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam int          CW    = $clog2(WIDTH + 1);
    localparam int          BW    = 4 * DIGITS;
    localparam logic [31:0] LIMIT = 32'(10 ** DIGITS - 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state_q;
    logic [WIDTH-1:0]  bin_q;
    logic [BW-1:0]     bcd_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_pending_q;
    logic              done_q;
    logic              overflow_q;
    logic [BW-1:0]     digits_q;

    logic [BW-1:0]       bcd_adj;
    logic [BW-1:0]       bcd_blank;
    logic [BW+WIDTH-1:0] shifted;
    logic                lead;

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Leading-zero suppression walks down from the top digit; digit 0 always shows.
    always_comb begin
        bcd_blank = bcd_q;
        lead      = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (BLANK_LZ != 0 && lead && bcd_q[4*k +: 4] == 4'd0)
                bcd_blank[4*k +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bin_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            digits_q      <= {DIGITS{4'hF}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bin_q         <= bus.value;
                        bcd_q         <= '0;
                        cnt_q         <= '0;
                        ovf_pending_q <= (32'(bus.value) > LIMIT);
                        state_q       <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= shifted;
                    cnt_q          <= cnt_q + CW'(1);
                    if (cnt_q == LAST)
                        state_q <= LATCH;
                end
                LATCH: begin
                    overflow_q <= ovf_pending_q;
                    digits_q   <= ovf_pending_q ? {DIGITS{4'hA}} : bcd_blank;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.digits   = digits_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three builds (4 digits blanked, 3 digits, 4 digits unblanked)
// share one request stream and are checked against a decimal arithmetic model.
module tb_bin2bcd_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_drv = 1'b0;
    logic [9:0] val_drv = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(10), .DIGITS(4)) if4 ();
    bin2bcd_seq_if #(.WIDTH(10), .DIGITS(3)) if3 ();
    bin2bcd_seq_if #(.WIDTH(10), .DIGITS(4)) ifn ();

    assign if4.start = start_drv;
    assign if4.value = val_drv;
    assign if3.start = start_drv;
    assign if3.value = val_drv;
    assign ifn.start = start_drv;
    assign ifn.value = val_drv;

    bin2bcd_seq #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    bin2bcd_seq #(.WIDTH(10), .DIGITS(3), .BLANK_LZ(1)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    bin2bcd_seq #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(0)) u_dutn (.clk(clk), .rst_n(rst_n), .bus(ifn));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Decimal display the decoders should see for value v on an nd-digit build.
    function automatic logic [19:0] model(input int v, input int nd, input bit blank, output bit ovf);
        logic [19:0] res;
        int lim;
        int x;
        res = '0;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ovf = (v > lim - 1);
        if (ovf) begin
            for (int i = 0; i < nd; i++) res[4*i +: 4] = 4'hA;
        end else begin
            x = v;
            for (int i = 0; i < nd; i++) begin
                res[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
            if (blank) begin
                for (int i = nd - 1; i >= 1; i--) begin
                    if (res[4*i +: 4] != 4'd0) break;
                    res[4*i +: 4] = 4'hF;
                end
            end
        end
        return res;
    endfunction

    task automatic check_results(input int v);
        logic [19:0] e;
        bit eo;
        e = model(v, 4, 1'b1, eo);
        check("dig4", 32'(if4.digits), 32'(e));
        check("ovf4", 32'(if4.overflow), 32'(eo));
        e = model(v, 3, 1'b1, eo);
        check("dig3", 32'(if3.digits), 32'(e));
        check("ovf3", 32'(if3.overflow), 32'(eo));
        e = model(v, 4, 1'b0, eo);
        check("dign", 32'(ifn.digits), 32'(e));
        check("ovfn", 32'(ifn.overflow), 32'(eo));
    endtask

    // One request; optionally fires an ignored start (value 99) mid-conversion.
    task automatic run_conv(input logic [9:0] v, input bit inject);
        int lat;
        int bcnt;
        int chg;
        logic [15:0] pre;
        @(negedge clk);
        start_drv = 1'b1;
        val_drv   = v;
        pre       = if4.digits;
        @(posedge clk);
        @(negedge clk);
        start_drv = 1'b0;
        val_drv   = 10'($urandom);
        lat = 0; bcnt = 0; chg = 0;
        for (int e = 1; e <= 20; e++) begin
            if (e > 1) @(negedge clk);
            if (inject && e == 4) begin start_drv = 1'b1; val_drv = 10'd99; end
            if (inject && e == 5) start_drv = 1'b0;
            if (if4.done && if3.done && ifn.done) begin
                lat = e;
                check("busy_at_done", 32'(if4.busy), 32'd0);
                break;
            end
            if (if4.busy && if3.busy && ifn.busy) bcnt++;
            if (if4.digits !== pre) chg++;
        end
        check("latency", 32'(lat), 32'd12);
        check("busy_cycles", 32'(bcnt), 32'd11);
        check("digits_stable", 32'(chg), 32'd0);
        check_results(int'(v));
        @(negedge clk);
        check("done_width", 32'({if4.done, if3.done, ifn.done}), 32'd0);
    endtask

    initial begin
        int pos[$];
        int ndone;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_digits", 32'(if4.digits), 32'h0000FFFF);
        check("rst_busy", 32'(if4.busy), 32'd0);

        run_conv(10'd0, 1'b0);
        check("v0", 32'(if4.digits), 32'h0000FFF0);
        run_conv(10'd305, 1'b0);
        check("v305", 32'(if4.digits), 32'h0000F305);

        // Asynchronous reset between edges
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_digits", 32'(if4.digits), 32'h0000FFFF);
        check("arst_flags", 32'({if4.busy, if4.done, if4.overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_conv(10'd1023, 1'b0);
        check("v1023", 32'(if4.digits), 32'h00001023);
        run_conv(10'd999, 1'b1);
        check("d3_999", 32'({if3.overflow, if3.digits}), 32'h00000999);
        run_conv(10'd1000, 1'b0);
        check("d3_1000", 32'({if3.overflow, if3.digits}), 32'h00001AAA);
        run_conv(10'd5, 1'b0);
        check("d3_5", 32'({if3.overflow, if3.digits}), 32'h00000FF5);
        run_conv(10'd42, 1'b1);
        check("nb_42", 32'(ifn.digits), 32'h00000042);

        for (int i = 0; i < 16; i++)
            run_conv(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));

        // start held high: back-to-back conversions
        @(negedge clk);
        start_drv = 1'b1;
        val_drv   = 10'd7;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (if4.done) begin
                pos.push_back(c);
                check_results(7);
            end
        end
        start_drv = 1'b0;
        ndone = pos.size();
        check("b2b_count", 32'(ndone), 32'd3);
        for (int i = 0; i < ndone; i++)
            check("b2b_pos", 32'(pos[i]), 32'(12 * (i + 1)));
        repeat (15) @(negedge clk);

        // Reset during SHIFT: aborted conversion never reports done
        start_drv = 1'b1;
        val_drv   = 10'd777;
        @(posedge clk);
        @(negedge clk);
        start_drv = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_digits", 32'(if4.digits), 32'h0000FFFF);
        check("mid_rst_busy", 32'(if4.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (if4.done || if3.done || ifn.done) ndone++;
        end
        check("mid_rst_nodone", 32'(ndone), 32'd0);
        check("mid_rst_hold", 32'(if4.digits), 32'h0000FFFF);
        run_conv(10'd8, 1'b0);
        check("after_rst_8", 32'(if4.digits), 32'h0000FFF8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (iterative double-dabble, one bit per clock) that sits directly upstream of the per-digit 7-segment decoders.
- Converts an unsigned binary value into DIGITS 4-bit codes, one per decoder instance.
- Emits the decoder's blank code (4'hF) for suppressed leading zeros and the "F" code (4'hA) on every digit for out-of-range values.
- Uses a start/busy/done handshake so a counter or measurement block can request a refresh at any rate.

Parameters:
- WIDTH, 10, width of the binary input value (1..16).
- DIGITS, 4, number of BCD digit outputs (1..5).
- BLANK_LZ, 1, 1 = leading-zero digits output 4'hF (blank); 0 = leading zeros output 4'h0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, sampled on the rising edge of clk.
- value  input  WIDTH  unsigned binary operand, captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; digits/overflow are valid and updated from this cycle on.
- digits  output  4*DIGITS  digit codes; digit 0 (least significant) is bits [3:0], digit k is bits [4k+3:4k].
- overflow  output  1  high when the last converted value exceeded 10^DIGITS-1.

Behaviour:
- Single clock. Reset is asynchronous and active-low: clk, rst_n.
- Reset values: state = IDLE; busy = 0; done = 0; overflow = 0; every digit = 4'hF (blank). Internal shift register and counter are cleared.
- FSM states: IDLE, SHIFT, LATCH.
- busy = (state != IDLE), decoded combinationally from the state register.
- IDLE:
  - start = 1 at an edge → capture value into the binary shift register, clear the BCD accumulator (4*DIGITS bits), set bit counter = 0, capture ovf_pending = (value > 10^DIGITS-1), go to SHIFT.
  - start = 0 → stay in IDLE.
- SHIFT, one bit per edge:
  - Each BCD nibble >= 5 gets +3.
  - Then {BCD, binary} shifts left by 1, MSB of binary first.
  - Counter increments; after WIDTH shift edges, go to LATCH.
  - BCD bits shifted past the top digit are discarded; the result is only used when ovf_pending = 0.
- LATCH, one edge:
  - overflow <= ovf_pending.
  - digits <= all 4'hA if ovf_pending, else the blanked BCD.
  - done <= 1; go to IDLE.
- done is registered: high for exactly the one cycle following the LATCH edge, low otherwise.
- Latency: done is high during the cycle after edge WIDTH+2, counting the start-accepting edge as edge 1 (12 edges for WIDTH = 10).
- Outputs hold between conversions. digits and overflow change only on the LATCH edge, never mid-conversion.
- Blanking (BLANK_LZ = 1):
  - Scan from the most significant digit down; each digit that is 0 and has only zero digits above it becomes 4'hF.
  - Digit 0 is never blanked, so value 0 displays "0".
  - Blanking is not applied on overflow.
- start while busy: ignored, with no effect on the running conversion or on the captured value.
- start during the done cycle: the FSM is already in IDLE, so the request is accepted and a new conversion begins back-to-back. done still pulses for the previous result.
- value changing after acceptance: no effect on the running conversion.
- rst_n low mid-conversion:
  - Immediate return to the reset values, including digits blanked.
  - done never pulses for the aborted conversion.
- The 10^DIGITS-1 limit is an elaboration-time constant. Comparison uses WIDTH+1 bits minimum so no truncation occurs.

Test Plan (WIDTH=10, DIGITS=4, BLANK_LZ=1 unless noted):
- Reset: assert rst_n=0 asynchronously between edges → busy=0, done=0, overflow=0, digits=16'hFFFF immediately.
- Conversions:
  - value=0 → digits=16'hFFF0.
  - value=305 → digits=16'hF305.
  - value=1023 → digits=16'h1023.
  - In each case done pulses exactly one cycle, 12 edges after the start edge; busy is high for edges 2..12.
- Back-to-back and ignored starts:
  - start=1 with value=7, held continuously → conversions run back-to-back, done every 12 cycles, digits=16'hFFF7.
  - A start pulse with value=99 issued mid-conversion → ignored.
- Overflow (DIGITS=3 build):
  - value=999 → digits=12'h999, overflow=0.
  - Then value=1000 → digits=12'hAAA, overflow=1.
  - Then value=5 → digits=12'hFF5, overflow=0.
- BLANK_LZ=0 build: value=42 → digits=16'h0042.
- Mid-conversion reset: rst_n pulsed low at SHIFT cycle 5 → no done pulse, digits=16'hFFFF. A following start with value=8 → digits=16'hFFF8 with normal latency.
